collision_mgr: RTL and testbench
================================

Name: collision_mgr

Overview:
- Multi-slot successor to the single-obstacle collision checker.
- Compares the player against N_OBST obstacle slots every cycle and emits a one-cycle despawn pulse per slot on the first overlapping cycle.
- Maintains hit count and lives, applies a frame-timed invulnerability window after each hit, and latches game over.
- Sits between the obstacle spawner/scroller and the game-state/score logic.

Parameters:
- VWIDTH, 12: signed vertical offset width.
- LWIDTH, 2: lane index width.
- N_OBST, 4: number of obstacle slots (1..16).
- POS_MISMATCH, 0: constant subtracted from obstacle voffset before comparison.
- POS_OFFSET, 5: half-window of the vertical overlap test (>=0).
- COUNT_WIDTH, 32: hit counter width.
- LIVES, 3: lives loaded at reset (1..15).
- INVULN_FRAMES, 60: frame_tick count of invulnerability after a hit (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- player_voffset  in  VWIDTH signed  player vertical position.
- player_lane  in  LWIDTH  player lane.
- obst_valid  in  N_OBST  slot occupied.
- obst_voffset  in  [N_OBST] x VWIDTH signed  per-slot vertical position.
- obst_lane  in  [N_OBST] x LWIDTH  per-slot lane.
- despawn  out  N_OBST  one-cycle per-slot removal pulse.
- hit_count  out  COUNT_WIDTH  accumulated hits, saturating.
- lives  out  4  remaining lives.
- invuln  out  1  high while in INVULN.
- game_over  out  1  high in DEAD.

Behaviour:
- Overlap[i] = obst_valid[i] && obst_lane[i]==player_lane && |(obst_voffset[i]-POS_MISMATCH) - player_voffset| <= POS_OFFSET.
  - All arithmetic sign-extended to VWIDTH+2 bits so no wrap occurs at extreme offsets.
- prev_ov[i] register holds last cycle's overlap.
- new_hit[i] = overlap[i] && !prev_ov[i].
  - A slot held overlapping produces exactly one event.
  - An invalid slot clears prev_ov[i].
- Latency: despawn[i] is registered and asserts the cycle after new_hit[i] is combinationally true. It lasts one cycle.
- Several slots may pulse despawn in the same cycle.
- FSM states ALIVE, INVULN, DEAD:
  - ALIVE, any new_hit: hit_count += 1 (saturate at all-ones), lives -= 1. If the decremented lives==0, go to DEAD; else go to INVULN with timer=INVULN_FRAMES.
  - INVULN: despawn still pulses on new_hit, but lives and hit_count are unchanged. Timer decrements on frame_tick. When a frame_tick finds timer==1, go to ALIVE the next cycle. A new_hit on that same cycle is ignored for lives.
  - DEAD: despawn forced 0, counters frozen, game_over=1. Only rst_n exits DEAD.
- frame_tick and new_hit on the same cycle in ALIVE: the hit is taken and the timer loads the full INVULN_FRAMES; that tick is not counted.
- Reset (any state, mid-window included): despawn=0, prev_ov=0, hit_count=0, lives=LIVES, timer=0, state=ALIVE, invuln=0, game_over=0.
  - Reset wins over all same-cycle events.
- All outputs are registered.

Optional Feature:
- Macro COLLISION_MULTI_HIT_EN.
- Defined: in ALIVE, hit_count adds popcount(new_hit), saturating. lives still decrements by exactly 1 per event cycle.
- Undefined: hit_count adds 1 per event cycle regardless of how many slots hit.

Decomposition:
- Package collision_pkg holds:
  - state enum (ALIVE, INVULN, DEAD), 2-bit.
  - lives_t (4-bit).
  - function for the sign-extended absolute-difference window test.
- Sub-module collision_slot, generated N_OBST times: overlap test, prev_ov register, new_hit output.
- collision_mgr keeps the FSM, counters and despawn registers.

Test Plan:
- Reset, then slot0 valid, lane 1, voffset 100; player lane 1, voffset 96 -> despawn=4'b0001 for exactly one cycle (cycle after the overlap appears); hit_count=1, lives=2, invuln=1.
- Hold the overlap 10 cycles -> no further despawn pulse. Deassert then reassert during INVULN -> despawn pulses again; lives stays 2, hit_count stays 1.
- Window edge: diff=5 -> hit; diff=6 -> no hit. Player voffset -2048 vs obstacle 2047 -> no hit (no wrap).
- INVULN_FRAMES=3: after a hit, three frame_ticks -> invuln drops, state ALIVE. Three hits separated by expired windows -> lives=0, game_over=1; later overlaps give despawn=0.
- Slots 0 and 2 hit in the same cycle in ALIVE -> despawn=4'b0101, lives-1. hit_count+1 without the macro, +2 with COLLISION_MULTI_HIT_EN.
- rst_n low in mid-INVULN, coincident with a new hit -> next cycle lives=LIVES, hit_count=0, despawn=0, invuln=0.

Source files
------------

// File: rtl/collision_pkg.sv
// collision_pkg: shared FSM state, lives type and overlap window test for the collision manager
package collision_pkg;
  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;
  typedef logic [3:0] lives_t;
  // Wide enough to hold any VWIDTH<=32 difference without wrap
  typedef logic signed [33:0] win_t;
  function automatic logic in_window(input win_t obst, input win_t player, input win_t mismatch, input win_t half);
    win_t d;
    d = obst - mismatch - player;
    return (d[33] ? -d : d) <= half;
  endfunction
endpackage

// File: rtl/collision_mgr_if.sv
// collision_mgr_if: player/obstacle inputs and despawn/game-state outputs of the collision manager
interface collision_mgr_if
  import collision_pkg::*;
#(
  parameter int VWIDTH = 12,
  parameter int LWIDTH = 2,
  parameter int N_OBST = 4,
  parameter int COUNT_WIDTH = 32
);
  logic frame_tick;
  logic signed [VWIDTH-1:0] player_voffset;
  logic [LWIDTH-1:0] player_lane;
  logic [N_OBST-1:0] obst_valid;
  logic [N_OBST-1:0][VWIDTH-1:0] obst_voffset;
  logic [N_OBST-1:0][LWIDTH-1:0] obst_lane;
  logic [N_OBST-1:0] despawn;
  logic [COUNT_WIDTH-1:0] hit_count;
  lives_t lives;
  logic invuln;
  logic game_over;
  modport master (
    output frame_tick, player_voffset, player_lane, obst_valid, obst_voffset, obst_lane,
    input despawn, hit_count, lives, invuln, game_over
  );
  modport slave (
    input frame_tick, player_voffset, player_lane, obst_valid, obst_voffset, obst_lane,
    output despawn, hit_count, lives, invuln, game_over
  );
endinterface

// File: rtl/collision_slot.sv
// collision_slot: per-slot overlap test with rising-edge detection so a held overlap yields one event
module collision_slot
  import collision_pkg::*;
#(
  parameter int VWIDTH = 12,
  parameter int LWIDTH = 2,
  parameter int POS_MISMATCH = 0,
  parameter int POS_OFFSET = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic signed [VWIDTH-1:0] voffset,
  input  logic [LWIDTH-1:0] lane,
  input  logic signed [VWIDTH-1:0] player_voffset,
  input  logic [LWIDTH-1:0] player_lane,
  output logic new_hit
);
  logic overlap, prev_ov_d, prev_ov_q;
  always_comb begin
    overlap = valid && lane == player_lane &&
              in_window(win_t'(voffset), win_t'(player_voffset), win_t'(POS_MISMATCH), win_t'(POS_OFFSET));
    prev_ov_d = overlap;
    new_hit = overlap && !prev_ov_q;
  end
  always_ff @(posedge clk) prev_ov_q <= !rst_n ? 1'b0 : prev_ov_d;
endmodule

// File: rtl/collision_mgr.sv
// collision_mgr: multi-slot collision checker with lives, invulnerability window and game over.
// COLLISION_MULTI_HIT_EN: hit_count adds the number of slots hit in a cycle instead of 1.
module collision_mgr
  import collision_pkg::*;
#(
  parameter int VWIDTH = 12,
  parameter int LWIDTH = 2,
  parameter int N_OBST = 4,
  parameter int POS_MISMATCH = 0,
  parameter int POS_OFFSET = 5,
  parameter int COUNT_WIDTH = 32,
  parameter int LIVES = 3,
  parameter int INVULN_FRAMES = 60
) (
  input logic clk,
  input logic rst_n,
  collision_mgr_if.slave bus
);
  localparam int TW = $clog2(INVULN_FRAMES + 1);
  localparam int CW1 = COUNT_WIDTH + 1;
  logic [N_OBST-1:0] new_hit, despawn_d, despawn_q;
  state_t state_d, state_q;
  logic [TW-1:0] timer_d, timer_q;
  logic [COUNT_WIDTH-1:0] hit_count_d, hit_count_q;
  logic [COUNT_WIDTH:0] sum;
  lives_t lives_d, lives_q;
  for (genvar i = 0; i < N_OBST; i++) begin : g_slot
    collision_slot #(
      .VWIDTH(VWIDTH), .LWIDTH(LWIDTH), .POS_MISMATCH(POS_MISMATCH), .POS_OFFSET(POS_OFFSET)
    ) u_slot (
      .clk(clk), .rst_n(rst_n), .valid(bus.obst_valid[i]), .voffset(bus.obst_voffset[i]),
      .lane(bus.obst_lane[i]), .player_voffset(bus.player_voffset), .player_lane(bus.player_lane),
      .new_hit(new_hit[i])
    );
  end
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    hit_count_d = hit_count_q;
    lives_d = lives_q;
`ifdef COLLISION_MULTI_HIT_EN
    sum = {1'b0, hit_count_q} + CW1'($countones(new_hit));
`else
    sum = {1'b0, hit_count_q} + CW1'(1);
`endif
    despawn_d = state_q == DEAD ? '0 : new_hit;
    case (state_q)
      ALIVE: if (|new_hit) begin
        hit_count_d = sum[COUNT_WIDTH] ? '1 : sum[COUNT_WIDTH-1:0];
        lives_d = lives_q - lives_t'(1);
        state_d = lives_d == '0 ? DEAD : INVULN;
        timer_d = lives_d == '0 ? '0 : TW'(INVULN_FRAMES);
      end
      // Hits during the window still despawn but never cost a life
      INVULN: if (bus.frame_tick) begin
        timer_d = timer_q - TW'(1);
        state_d = timer_q == TW'(1) ? ALIVE : INVULN;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ALIVE;
      timer_q <= '0;
      hit_count_q <= '0;
      lives_q <= lives_t'(LIVES);
      despawn_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      hit_count_q <= hit_count_d;
      lives_q <= lives_d;
      despawn_q <= despawn_d;
    end
  end
  assign bus.despawn = despawn_q;
  assign bus.hit_count = hit_count_q;
  assign bus.lives = lives_q;
  assign bus.invuln = state_q == INVULN;
  assign bus.game_over = state_q == DEAD;
endmodule

// File: tb/tb_collision_mgr.sv
// tb_collision_mgr: directed stimulus with a per-cycle reference model of lives/window/despawn rules
module tb_collision_mgr;
  localparam int N = 4;
  localparam int VW = 12;
  localparam int LV = 3;
  localparam int FR = 3;
  localparam int MIS = 0;
  localparam int OFF = 5;
`ifdef COLLISION_MULTI_HIT_EN
  localparam int MULTI = 1;
  localparam int MULTI_HC = 4;
`else
  localparam int MULTI = 0;
  localparam int MULTI_HC = 3;
`endif
  logic clk, rst_n;
  int total = 0, bad = 0;
  collision_mgr_if #(.VWIDTH(VW), .LWIDTH(2), .N_OBST(N), .COUNT_WIDTH(32)) bus ();
  collision_mgr #(
    .VWIDTH(VW), .LWIDTH(2), .N_OBST(N), .POS_MISMATCH(MIS), .POS_OFFSET(OFF),
    .COUNT_WIDTH(32), .LIVES(LV), .INVULN_FRAMES(FR)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  // Inputs as seen by the DUT at the last rising edge
  logic s_rst, s_tick;
  logic [N-1:0] s_valid;
  int s_pv, s_pl;
  int s_vo[N];
  int s_lane[N];
  always @(posedge clk) begin
    s_rst <= rst_n;
    s_tick <= bus.frame_tick;
    s_valid <= bus.obst_valid;
    s_pv <= int'($signed(bus.player_voffset));
    s_pl <= int'(bus.player_lane);
    for (int i = 0; i < N; i++) begin
      s_vo[i] <= int'($signed(bus.obst_voffset[i]));
      s_lane[i] <= int'(bus.obst_lane[i]);
    end
  end
  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction
  logic [N-1:0] m_prev, m_desp, m_nh;
  longint m_hits;
  int m_lives, m_left;
  bit m_ov;
  always @(negedge clk) begin
    if (!s_rst) begin
      m_prev = '0; m_desp = '0; m_hits = 0; m_lives = LV; m_left = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        m_ov = s_valid[i] && s_lane[i] == s_pl && iabs(s_vo[i] - MIS - s_pv) <= OFF;
        m_nh[i] = m_ov && !m_prev[i];
        m_prev[i] = m_ov;
      end
      m_desp = m_lives == 0 ? '0 : m_nh;
      if (m_lives > 0) begin
        if (m_left == 0) begin
          if (m_nh != 0) begin
            m_hits = m_hits + (MULTI != 0 ? $countones(m_nh) : 1);
            if (m_hits > 64'hFFFF_FFFF) m_hits = 64'hFFFF_FFFF;
            m_lives = m_lives - 1;
            m_left = m_lives > 0 ? FR : 0;
          end
        end else if (s_tick) m_left = m_left - 1;
      end
    end
    total++;
    if (bus.despawn !== m_desp || bus.hit_count !== 32'(m_hits) || bus.lives !== 4'(m_lives) ||
        bus.invuln !== (m_left > 0) || bus.game_over !== (m_lives == 0)) begin
      bad++;
      $display("FAIL model t=%0t: got desp=%b hc=%0d lives=%0d inv=%b go=%b want desp=%b hc=%0d lives=%0d inv=%b go=%b",
               $time, bus.despawn, bus.hit_count, bus.lives, bus.invuln, bus.game_over,
               m_desp, m_hits, m_lives, m_left > 0, m_lives == 0);
    end
  end
  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic expire();
    repeat (FR) begin
      bus.frame_tick = 1; cyc();
      bus.frame_tick = 0; cyc();
    end
  endtask
  initial begin
    rst_n = 0;
    bus.frame_tick = 0;
    bus.player_voffset = 12'd96;
    bus.player_lane = 2'd1;
    bus.obst_valid = '0;
    bus.obst_voffset = '0;
    bus.obst_lane = '0;
    cyc(2);
    chk("rst_lives", bus.lives, 3);
    chk("rst_hc", bus.hit_count, 0);
    chk("rst_desp", bus.despawn, 0);
    chk("rst_inv", bus.invuln, 0);
    chk("rst_go", bus.game_over, 0);
    rst_n = 1; cyc();
    bus.obst_lane[0] = 2'd1; bus.obst_voffset[0] = 12'd100; bus.obst_valid = 4'b0001; cyc();
    chk("hit1_desp", bus.despawn, 4'b0001);
    chk("hit1_hc", bus.hit_count, 1);
    chk("hit1_lives", bus.lives, 2);
    chk("hit1_inv", bus.invuln, 1);
    cyc();
    chk("pulse_once", bus.despawn, 0);
    cyc(9);
    chk("hold_desp", bus.despawn, 0);
    chk("hold_lives", bus.lives, 2);
    bus.obst_valid = 4'b0000; cyc();
    bus.obst_valid = 4'b0001; cyc();
    chk("inv_desp", bus.despawn, 4'b0001);
    chk("inv_lives", bus.lives, 2);
    chk("inv_hc", bus.hit_count, 1);
    expire();
    chk("expire_inv", bus.invuln, 0);
    chk("expire_lives", bus.lives, 2);
    bus.obst_valid = 4'b0000; bus.obst_voffset[0] = 12'd101; cyc();
    bus.obst_valid = 4'b0001; cyc();
    chk("diff5_desp", bus.despawn, 4'b0001);
    chk("diff5_lives", bus.lives, 1);
    chk("diff5_hc", bus.hit_count, 2);
    expire();
    bus.obst_valid = 4'b0000; bus.obst_voffset[0] = 12'd102; cyc();
    bus.obst_valid = 4'b0001; cyc();
    chk("diff6_desp", bus.despawn, 0);
    chk("diff6_lives", bus.lives, 1);
    bus.player_voffset = 12'h800; bus.obst_voffset[0] = 12'h7FF; cyc();
    chk("nowrap_desp", bus.despawn, 0);
    chk("nowrap_lives", bus.lives, 1);
    bus.player_voffset = 12'd96; bus.obst_valid = 4'b0000;
    bus.obst_lane[0] = 2'd1; bus.obst_voffset[0] = 12'd100;
    bus.obst_lane[1] = 2'd2; bus.obst_voffset[1] = 12'd100;
    bus.obst_lane[2] = 2'd1; bus.obst_voffset[2] = 12'd91;
    bus.obst_lane[3] = 2'd1; bus.obst_voffset[3] = 12'd200;
    cyc();
    bus.obst_valid = 4'b1111; cyc();
    chk("multi_desp", bus.despawn, 4'b0101);
    chk("multi_lives", bus.lives, 0);
    chk("multi_hc", bus.hit_count, MULTI_HC);
    chk("multi_go", bus.game_over, 1);
    bus.obst_valid = 4'b0000; cyc();
    bus.obst_valid = 4'b1111; bus.frame_tick = 1; cyc();
    bus.frame_tick = 0;
    chk("dead_desp", bus.despawn, 0);
    chk("dead_go", bus.game_over, 1);
    chk("dead_hc", bus.hit_count, MULTI_HC);
    rst_n = 0; bus.obst_valid = 4'b0000; cyc();
    chk("rst2_go", bus.game_over, 0);
    chk("rst2_lives", bus.lives, 3);
    rst_n = 1; cyc();
    bus.obst_valid = 4'b0001; bus.frame_tick = 1; cyc();
    chk("tickhit_desp", bus.despawn, 4'b0001);
    chk("tickhit_lives", bus.lives, 2);
    bus.frame_tick = 0;
    repeat (2) begin
      bus.frame_tick = 1; cyc();
      bus.frame_tick = 0; cyc();
    end
    chk("tickhit_still_inv", bus.invuln, 1);
    bus.obst_valid = 4'b0000; cyc();
    bus.obst_valid = 4'b0001; rst_n = 0; cyc();
    chk("rsthit_lives", bus.lives, 3);
    chk("rsthit_hc", bus.hit_count, 0);
    chk("rsthit_desp", bus.despawn, 0);
    chk("rsthit_inv", bus.invuln, 0);
    rst_n = 1; bus.obst_valid = 4'b0000; cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
